// File: rtl/maxnet_pkg.sv
// Shared constants for the Maxnet sequencing controller.
// State encoding and default run-length settings.
package maxnet_pkg;

  localparam int LAT_W = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int DEF_MAX_ITER   = 32;
  localparam int DEF_ITER_W     = 8;
  localparam int DEF_PU_LATENCY = 1;

endpackage

// File: rtl/up_counter.sv
// Clearable up-counter; clear wins over increment.
// Used for the Maxnet iteration count.
module up_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/maxnet_controller.sv
// Sequencing FSM for the 4-neuron Maxnet datapath.
// Loads activations, then iterates PU updates until one winner or MAX_ITER.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int MAX_ITER   = DEF_MAX_ITER,
  parameter int ITER_W     = DEF_ITER_W,
  parameter int PU_LATENCY = DEF_PU_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_finished,
  output logic              load_a,
  output logic              load_sel,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [ITER_W-1:0] MAX_C = ITER_W'(MAX_ITER);
  localparam logic [LAT_W-1:0]  LAT_C = LAT_W'(PU_LATENCY);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [LAT_W-1:0] wait_q;
  logic [LAT_W-1:0] wait_d;
  logic             timeout_q;
  logic             timeout_d;
  logic             it_clr;
  logic             it_inc;

  // Iteration count and timeout are cleared when a start is accepted.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    it_clr    = 1'b0;
    it_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_INIT;
          timeout_d = 1'b0;
          it_clr    = 1'b1;
        end
      end
      S_INIT: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (is_finished) begin
          state_d = S_DONE;
        end else if (iter_count == MAX_C) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          wait_d  = LAT_C;
          state_d = (LAT_C == '0) ? S_UPDATE : S_WAIT;
        end
      end
      S_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q <= 1) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        it_inc  = 1'b1;
        state_d = S_CHECK;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  up_counter #(
    .W(ITER_W)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .clr  (it_clr),
    .inc  (it_inc),
    .count(iter_count)
  );

  assign load_a   = (state_q == S_INIT) || (state_q == S_UPDATE);
  assign load_sel = (state_q == S_INIT);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Scoreboard bench for maxnet_controller across four parameter sets.
// DUT0 default, DUT1 MAX_ITER=4, DUT2 PU_LATENCY=0, DUT3 MAX_ITER=2.
module tb_maxnet_controller;
  import maxnet_pkg::*;

  typedef struct {
    logic to;
    int   iter;
    int   done_cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] start;
  logic [3:0] fin;
  logic [3:0] load_a;
  logic [3:0] load_sel;
  logic [3:0] busy;
  logic [3:0] done;
  logic [3:0] timeout;
  logic [7:0] iter_count [4];

  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    maxnet_controller #(
      .MAX_ITER  (g == 1 ? 4 : (g == 3 ? 2 : DEF_MAX_ITER)),
      .ITER_W    (8),
      .PU_LATENCY(g == 2 ? 0 : DEF_PU_LATENCY)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[g]),
      .is_finished(fin[g]),
      .load_a     (load_a[g]),
      .load_sel   (load_sel[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .timeout    (timeout[g]),
      .iter_count (iter_count[g])
    );
  end

  task automatic test_reset();
    rst = 1'b1;
    start = '0;
    fin = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if ({load_a[d], load_sel[d], busy[d], done[d], timeout[d]} !== 5'b0 ||
          iter_count[d] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: outs=%b iter=%0d, need outs=00000 iter=0", d,
                 {load_a[d], load_sel[d], busy[d], done[d], timeout[d]}, iter_count[d]);
      end
    end
  endtask

  // Runs one evaluation; is_finished rises after `target` UPDATE pulses.
  task automatic run_eval(input int d, input int target, input int lat, input int max_it);
    exp_t e;
    int   upd_q[$];
    int   rel;
    int   upd;
    int   n;
    int   want;
    bit   got;
    n = (target < max_it) ? target : max_it;
    e.to = (target > max_it);
    e.iter = n;
    e.done_cyc = 3 + n * (2 + lat);
    sb.push_back(e);
    for (int k = 1; k <= n; k++) upd_q.push_back(1 + k * (2 + lat));
    @(negedge clk);
    start[d] = 1'b1;
    fin[d] = (target == 0);
    upd = 0;
    rel = 0;
    got = 0;
    while (!got && rel < 400) begin
      @(negedge clk);
      rel++;
      start[d] = 1'b0;
      if (rel == 1) begin
        n_checks++;
        if (load_a[d] !== 1'b1 || load_sel[d] !== 1'b1 || busy[d] !== 1'b1) begin
          n_fail++;
          $display("FAIL init dut%0d: load_a=%b load_sel=%b busy=%b, need 1 1 1", d,
                   load_a[d], load_sel[d], busy[d]);
        end
      end
      if (rel == 2) begin
        n_checks++;
        if (timeout[d] !== 1'b0 || iter_count[d] !== 8'd0) begin
          n_fail++;
          $display("FAIL clear dut%0d: timeout=%b iter=%0d, need 0 0", d,
                   timeout[d], iter_count[d]);
        end
      end
      if (load_sel[d] === 1'b1 && rel != 1) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_init dut%0d: load_sel=1 at cycle %0d, need only cycle 1", d, rel);
      end
      if (load_a[d] === 1'b1 && load_sel[d] === 1'b0) begin
        n_checks++;
        want = (upd_q.size() > 0) ? upd_q.pop_front() : -1;
        if (rel != want) begin
          n_fail++;
          $display("FAIL update_cyc dut%0d: pulse at %0d, need %0d", d, rel, want);
        end
        upd++;
        fin[d] = (upd >= target);
      end
      if (done[d] === 1'b1) begin
        got = 1;
        e = sb.pop_front();
        n_checks++;
        if (rel != e.done_cyc || timeout[d] !== e.to || iter_count[d] !== 8'(e.iter)) begin
          n_fail++;
          $display("FAIL done dut%0d: cyc=%0d to=%b iter=%0d, need cyc=%0d to=%b iter=%0d",
                   d, rel, timeout[d], iter_count[d], e.done_cyc, e.to, e.iter);
        end
      end
    end
    n_checks++;
    if (!got || upd_q.size() != 0) begin
      n_fail++;
      $display("FAIL run_end dut%0d: got_done=%0d missing_updates=%0d, need 1 0", d,
               got, upd_q.size());
    end
    @(negedge clk);
    n_checks++;
    if (busy[d] !== 1'b0 || done[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle dut%0d: busy=%b done=%b, need 0 0", d, busy[d], done[d]);
    end
    fin[d] = 1'b0;
  endtask

  task automatic test_immediate();
    run_eval(0, 0, 1, DEF_MAX_ITER);
  endtask

  task automatic test_converge();
    run_eval(0, 3, 1, DEF_MAX_ITER);
  endtask

  task automatic test_timeout();
    run_eval(1, 255, 1, 4);
    repeat (5) @(negedge clk);
    n_checks++;
    if (timeout[1] !== 1'b1 || iter_count[1] !== 8'd4) begin
      n_fail++;
      $display("FAIL timeout_hold: timeout=%b iter=%0d, need 1 4", timeout[1], iter_count[1]);
    end
    run_eval(1, 0, 1, 4);
  endtask

  task automatic test_coincide();
    run_eval(3, 2, 1, 2);
    run_eval(1, 4, 1, 4);
  endtask

  task automatic test_lat0();
    run_eval(2, 3, 0, DEF_MAX_ITER);
  endtask

  task automatic test_back_to_back();
    int rel;
    int upd;
    int inits;
    @(negedge clk);
    start[0] = 1'b1;
    fin[0] = 1'b0;
    rel = 0;
    upd = 0;
    inits = 0;
    while (rel < 9) begin
      @(negedge clk);
      rel++;
      if (load_sel[0] === 1'b1) inits++;
      if (load_a[0] === 1'b1 && load_sel[0] === 1'b0) begin
        upd++;
        fin[0] = (upd >= 2);
      end
    end
    n_checks++;
    if (done[0] !== 1'b1 || inits != 1) begin
      n_fail++;
      $display("FAIL busy_start: done=%b inits=%0d at cycle 9, need 1 1", done[0], inits);
    end
    @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm_idle: busy=%b at cycle 10, need 0", busy[0]);
    end
    @(negedge clk);
    start[0] = 1'b0;
    fin[0] = 1'b1;
    n_checks++;
    if (load_sel[0] !== 1'b1 || load_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm_init: load_sel=%b load_a=%b at cycle 11, need 1 1",
               load_sel[0], load_a[0]);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (done[0] !== 1'b1 || iter_count[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL rearm_done: done=%b iter=%0d at cycle 13, need 1 0", done[0], iter_count[0]);
    end
    @(negedge clk);
    fin[0] = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int  rel;
    bit  seen;
    @(negedge clk);
    start[0] = 1'b1;
    fin[0] = 1'b0;
    rel = 0;
    while (rel < 6) begin
      @(negedge clk);
      rel++;
      start[0] = 1'b0;
    end
    n_checks++;
    if (busy[0] !== 1'b1 || load_a[0] !== 1'b0 || iter_count[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL wait2: busy=%b load_a=%b iter=%0d, need 1 0 1", busy[0], load_a[0],
               iter_count[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({load_a[0], load_sel[0], busy[0], done[0], timeout[0]} !== 5'b0 ||
        iter_count[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL midrun_rst: outs=%b iter=%0d, need outs=00000 iter=0",
               {load_a[0], load_sel[0], busy[0], done[0], timeout[0]}, iter_count[0]);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done[0] === 1'b1 || busy[0] === 1'b1) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL post_rst: activity after reset=1, need 0");
    end
    run_eval(0, 1, 1, DEF_MAX_ITER);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_immediate();
    test_converge();
    test_timeout();
    test_coincide();
    test_lat0();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
